// File: rtl/cpu_monitor_pkg.sv
// Shared types for the CPU run monitor: FSM states, halt-cause codes, trace kinds
// and the trace-entry width helper.
package cpu_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_DONE    = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   localparam logic KIND_REG = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   // Entry layout is {cycle, kind, addr, data}.
   function automatic int trace_w(input int cycle_w, input int data_w);
      return cycle_w + 1 + 2 * data_w;
   endfunction

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// trace_fifo: synchronous FIFO with two push ports (port 0 has priority), one pop port
// and a sticky overflow flag for any push that found no room.
module trace_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push0_i,
   input  logic [W-1:0] din0_i,
   input  logic         push1_i,
   input  logic [W-1:0] din1_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] dout_o,
   output logic         overflow_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_q, wr_d, rd_q, rd_d, used, avail, wr_next0;
   logic [W-1:0]  mem_q [DEPTH];
   logic          ovf_q, ovf_d;
   logic          empty, full, pop, acc0, acc1;
   logic [AW-1:0] waddr0, waddr1;

   // A pop in the same cycle frees its slot, so a full FIFO still accepts a push.
   always_comb begin
      empty    = (wr_q == rd_q);
      full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop      = !empty && ready_i;
      used     = wr_q - rd_q;
      avail    = (AW+1)'(DEPTH) - used + (AW+1)'(pop);
      acc0     = push0_i && (!full || pop);
      acc1     = push1_i && (avail >= (acc0 ? (AW+1)'(2) : (AW+1)'(1)));
      wr_next0 = wr_q + (AW+1)'(acc0);
      waddr0   = wr_q[AW-1:0];
      waddr1   = wr_next0[AW-1:0];
      wr_d     = wr_next0 + (AW+1)'(acc1);
      rd_d     = rd_q + (AW+1)'(pop);
      ovf_d    = ovf_q || (push0_i && !acc0) || (push1_i && !acc1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc0) mem_q[waddr0] <= din0_i;
      if (acc1) mem_q[waddr1] <= din1_i;
   end

   assign valid_o    = !empty;
   assign dout_o     = mem_q[rd_q[AW-1:0]];
   assign overflow_o = ovf_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: cycle counter, halt/drain/watchdog FSM and trace capture beside the CPU.
// Define MEM_TRACE_EN to also trace memory writes.
module cpu_run_monitor
   import cpu_monitor_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 5,
   parameter int CYCLE_W      = 16,
   parameter int FORCE_STOP   = 1000,
   parameter int STAGES       = 5,
   parameter int DRAIN_CYCLES = 2,
   parameter int TRACE_DEPTH  = 16
) (
   input  logic                                 CLOCK,
   input  logic                                 RESET,
   input  logic                                 HaltReq,
   input  logic [STAGES-1:0]                    StageValid,
   input  logic                                 RegWriteEN_W,
   input  logic [REG_AW-1:0]                    RegAddr3_W,
   input  logic [DATA_W-1:0]                    RegWriteData_W,
   input  logic                                 MemWriteEN_M,
   input  logic [DATA_W-1:0]                    ALUOut_M,
   input  logic [DATA_W-1:0]                    MemWriteData_M,
   output logic [CYCLE_W-1:0]                   CycleCount,
   output logic                                 Halted,
   output logic [1:0]                           HaltCause,
   output logic                                 TraceValid,
   input  logic                                 TraceReady,
   output logic [trace_w(CYCLE_W, DATA_W)-1:0]  TraceData,
   output logic                                 TraceOverflow,
   output logic [1:0]                           DebugState
);

   localparam int                 TRACE_W    = trace_w(CYCLE_W, DATA_W);
   localparam int                 DC_W       = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CYCLE_W-1:0] STOP_AT    = CYCLE_W'(FORCE_STOP - 1);
   localparam logic [DC_W-1:0]    DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic [DC_W-1:0]    drain_q, drain_d;
   logic               halted_q, halted_d;
   logic [1:0]         cause_q, cause_d;

   logic               reg_push, mem_push;
   logic [TRACE_W-1:0] reg_entry, mem_entry;

   // The watchdog check comes last so it overrides a same-cycle drain completion.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      cause_d = cause_q;
      case (state_q)
         ST_RUN: begin
            if (HaltReq) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (StageValid == '0) begin
               if (drain_q == DRAIN_LAST) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_DONE;
               end else begin
                  drain_d = drain_q + 1'b1;
               end
            end else begin
               drain_d = '0;
            end
         end
         default: ;
      endcase
      if (state_q != ST_HALTED && cycle_q == STOP_AT) begin
         state_d = ST_HALTED;
         cause_d = CAUSE_TIMEOUT;
      end
      halted_d = (state_d == ST_HALTED);
      cycle_d  = cycle_q;
      if (state_d != ST_HALTED && cycle_q != '1) cycle_d = cycle_q + 1'b1;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= ST_RUN;
         cycle_q  <= '0;
         drain_q  <= '0;
         halted_q <= 1'b0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         drain_q  <= drain_d;
         halted_q <= halted_d;
         cause_q  <= cause_d;
      end
   end

   assign reg_push  = RegWriteEN_W && (RegAddr3_W != '0) && (state_q != ST_HALTED);
   assign reg_entry = {cycle_q, KIND_REG, DATA_W'(RegAddr3_W), RegWriteData_W};

`ifdef MEM_TRACE_EN
   assign mem_push  = MemWriteEN_M && (state_q != ST_HALTED);
   assign mem_entry = {cycle_q, KIND_MEM, ALUOut_M, MemWriteData_M};
`else
   assign mem_push  = 1'b0;
   assign mem_entry = '0;
   logic unused_mem;
   assign unused_mem = ^{MemWriteEN_M, ALUOut_M, MemWriteData_M};
`endif

   // Trace port: TraceData is meaningful while TraceValid; an entry leaves on a cycle
   // where TraceValid && TraceReady, and the consumer may hold TraceReady freely.
   trace_fifo #(
      .W     (TRACE_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk        (CLOCK),
      .rst        (RESET),
      .push0_i    (reg_push),
      .din0_i     (reg_entry),
      .push1_i    (mem_push),
      .din1_i     (mem_entry),
      .ready_i    (TraceReady),
      .valid_o    (TraceValid),
      .dout_o     (TraceData),
      .overflow_o (TraceOverflow)
   );

   assign CycleCount = cycle_q;
   assign Halted     = halted_q;
   assign HaltCause  = cause_q;
   assign DebugState = state_q;

endmodule
